// File: rtl/space_invaders_pkg.sv
// Shared constants and types for the space invaders video pipeline.
package space_invaders_pkg;

  localparam int FIXED_POINT_MULTIPLIER = 64;
  localparam int SCREEN_W               = 640;
  localparam int SCREEN_H               = 480;
  localparam int SafetyMargin           = 2;
  localparam int y_FRAME_TOP            = SafetyMargin * FIXED_POINT_MULTIPLIER;

  typedef enum logic [2:0] {
    IDLE_ST,
    READY_ST,
    FLIGHT_ST,
    SOF_ST,
    POSITION_CHANGE_ST,
    POSITION_LIMITS_ST,
    COOLDOWN_ST
  } missile_state_t;

endpackage

// File: rtl/rise_edge_detect.sv
// One-cycle pulse on a rising edge of a level input (key debounce is upstream).
module rise_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic in_d;
  logic in_q;

  always_comb in_d = in;

  always_ff @(posedge clk) begin
    if (reset) in_q <= 1'b0;
    else       in_q <= in_d;
  end

  assign pulse = in & ~in_q;

endmodule

// File: rtl/spaceship_missile_move.sv
// Player missile: launches from the ship nose, climbs at fixed speed, retires on
// collision or at the top edge, then waits out a cooldown before the next shot.
module spaceship_missile_move
  import space_invaders_pkg::*;
#(
  parameter int          MISSILE_SPEED_Y = 256,
  parameter int          MISSILE_WIDTH   = 4,
  parameter int          MISSILE_HEIGHT  = 16,
  parameter int          SHIP_WIDTH      = 32,
  parameter int unsigned COOLDOWN_FRAMES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               enable_sof,
  input  logic               shoot,
  input  logic               collision,
  input  logic signed [10:0] shipTopLeftX,
  input  logic signed [10:0] shipTopLeftY,
  output logic signed [10:0] missileTopLeftX,
  output logic signed [10:0] missileTopLeftY,
  output logic               missileActive,
  output logic               firePulse
);

  localparam int unsigned CNT_W =
    (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  // With no cooldown a retired missile goes straight back to arming.
  localparam missile_state_t RETIRE_ST =
    (COOLDOWN_FRAMES == 0) ? READY_ST : COOLDOWN_ST;

  missile_state_t   state_q, state_d;
  logic             fire_req_q, fire_req_d;
  logic             hit_flag_q, hit_flag_d;
  logic [CNT_W-1:0] cool_cnt_q, cool_cnt_d;
  int               xpos_q, xpos_d;
  int               ypos_q, ypos_d;
  logic             missile_active_q, missile_active_d;
  logic             fire_pulse_q, fire_pulse_d;

  logic frame_tick;
  logic shoot_rise;
  logic launch;
  int   launch_x;
  int   launch_y;

  rise_edge_detect u_shoot_edge (
    .clk   (clk),
    .reset (reset),
    .in    (shoot),
    .pulse (shoot_rise)
  );

  assign frame_tick = startOfFrame & enable_sof;
  assign launch     = (state_q == READY_ST) & frame_tick & fire_req_q;
  assign launch_x   = (int'(shipTopLeftX) + SHIP_WIDTH / 2 - MISSILE_WIDTH / 2)
                      * FIXED_POINT_MULTIPLIER;
  assign launch_y   = (int'(shipTopLeftY) - MISSILE_HEIGHT) * FIXED_POINT_MULTIPLIER;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE_ST;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE_ST:            if (frame_tick) state_d = READY_ST;
      READY_ST:           if (launch) state_d = FLIGHT_ST;
      FLIGHT_ST:          if (frame_tick) state_d = SOF_ST;
      SOF_ST:             state_d = hit_flag_q ? RETIRE_ST : POSITION_CHANGE_ST;
      POSITION_CHANGE_ST: state_d = POSITION_LIMITS_ST;
      POSITION_LIMITS_ST: state_d = (ypos_q < y_FRAME_TOP) ? RETIRE_ST : FLIGHT_ST;
      COOLDOWN_ST:        if (cool_cnt_q == '0) state_d = READY_ST;
      default:            state_d = IDLE_ST;
    endcase
  end

  // Datapath updates; fire_req only survives while armed so shots never queue.
  always_comb begin
    fire_req_d       = 1'b0;
    hit_flag_d       = hit_flag_q;
    cool_cnt_d       = cool_cnt_q;
    xpos_d           = xpos_q;
    ypos_d           = ypos_q;
    missile_active_d = missile_active_q;
    fire_pulse_d     = 1'b0;
    unique case (state_q)
      READY_ST: begin
        fire_req_d = fire_req_q | shoot_rise;
        if (launch) begin
          xpos_d           = launch_x;
          ypos_d           = launch_y;
          missile_active_d = 1'b1;
          fire_pulse_d     = 1'b1;
          fire_req_d       = 1'b0;
        end
      end
      FLIGHT_ST: hit_flag_d = hit_flag_q | collision;
      SOF_ST: begin
        if (hit_flag_q) begin
          hit_flag_d       = 1'b0;
          missile_active_d = 1'b0;
          cool_cnt_d       = CNT_W'(COOLDOWN_FRAMES);
        end
      end
      POSITION_CHANGE_ST: ypos_d = ypos_q - MISSILE_SPEED_Y;
      POSITION_LIMITS_ST: begin
        if (ypos_q < y_FRAME_TOP) begin
          missile_active_d = 1'b0;
          cool_cnt_d       = CNT_W'(COOLDOWN_FRAMES);
        end
      end
      COOLDOWN_ST: begin
        if (frame_tick && cool_cnt_q != '0) cool_cnt_d = cool_cnt_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fire_req_q       <= 1'b0;
      hit_flag_q       <= 1'b0;
      cool_cnt_q       <= '0;
      xpos_q           <= 0;
      ypos_q           <= 0;
      missile_active_q <= 1'b0;
      fire_pulse_q     <= 1'b0;
    end else begin
      fire_req_q       <= fire_req_d;
      hit_flag_q       <= hit_flag_d;
      cool_cnt_q       <= cool_cnt_d;
      xpos_q           <= xpos_d;
      ypos_q           <= ypos_d;
      missile_active_q <= missile_active_d;
      fire_pulse_q     <= fire_pulse_d;
    end
  end

  assign missileTopLeftX = 11'(xpos_q / FIXED_POINT_MULTIPLIER);
  assign missileTopLeftY = 11'(ypos_q / FIXED_POINT_MULTIPLIER);
  assign missileActive   = missile_active_q;
  assign firePulse       = fire_pulse_q;

endmodule

// File: tb/tb_spaceship_missile_move.sv
// Scoreboard bench for spaceship_missile_move: expected launch/retire events are
// queued by the stimulus and checked by a monitor when the DUT produces them.
module tb_spaceship_missile_move;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               startOfFrame = 1'b0;
  logic               enable_sof = 1'b1;
  logic               shoot = 1'b0;
  logic               collision = 1'b0;
  logic signed [10:0] shipTopLeftX = 11'sd0;
  logic signed [10:0] shipTopLeftY = 11'sd0;
  logic signed [10:0] missileTopLeftX;
  logic signed [10:0] missileTopLeftY;
  logic               missileActive;
  logic               firePulse;

  typedef struct {
    bit is_launch;
    int x;
    int y;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  spaceship_missile_move dut (
    .clk             (clk),
    .reset           (reset),
    .startOfFrame    (startOfFrame),
    .enable_sof      (enable_sof),
    .shoot           (shoot),
    .collision       (collision),
    .shipTopLeftX    (shipTopLeftX),
    .shipTopLeftY    (shipTopLeftY),
    .missileTopLeftX (missileTopLeftX),
    .missileTopLeftY (missileTopLeftY),
    .missileActive   (missileActive),
    .firePulse       (firePulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input bit is_launch, input int x, input int y);
    ev_t e;
    e.is_launch = is_launch;
    e.x = x;
    e.y = y;
    exp_q.push_back(e);
  endtask

  // One frame: a single-cycle start-of-frame pulse followed by idle cycles.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) startOfFrame = 1'b1;
      @(negedge clk) startOfFrame = 1'b0;
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic frame_with_collision();
    @(negedge clk) begin startOfFrame = 1'b1; collision = 1'b1; end
    @(negedge clk) begin startOfFrame = 1'b0; collision = 1'b0; end
    repeat (5) @(negedge clk);
  endtask

  task automatic press_shoot();
    @(negedge clk) shoot = 1'b1;
    @(negedge clk) shoot = 1'b0;
  endtask

  task automatic pulse_collision();
    @(negedge clk) collision = 1'b1;
    @(negedge clk) collision = 1'b0;
  endtask

  // Monitor: pops an expected event on every launch pulse and every retirement.
  initial begin : monitor
    bit   prev_active;
    ev_t  e;
    prev_active = 1'b0;
    forever begin
      @(negedge clk);
      if (firePulse) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_launch: got launch at (%0d,%0d) expected none at %0t",
                   missileTopLeftX, missileTopLeftY, $time);
        end else begin
          e = exp_q.pop_front();
          check("launch_kind", 1, int'(e.is_launch));
          check("launch_x", int'(missileTopLeftX), e.x);
          check("launch_y", int'(missileTopLeftY), e.y);
          check("launch_active", int'(missileActive), 1);
        end
      end
      if (prev_active && !missileActive) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_retire: got retire at y=%0d expected none at %0t",
                   missileTopLeftY, $time);
        end else begin
          e = exp_q.pop_front();
          check("retire_kind", 0, int'(e.is_launch));
          check("retire_x", int'(missileTopLeftX), e.x);
          check("retire_y", int'(missileTopLeftY), e.y);
        end
      end
      prev_active = missileActive;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_active", int'(missileActive), 0);
    check("rst_fire", int'(firePulse), 0);
    check("rst_x", int'(missileTopLeftX), 0);
    check("rst_y", int'(missileTopLeftY), 0);

    // Basic launch from ship at (280,185) -> missile at (294,169).
    shipTopLeftX = 11'sd280;
    shipTopLeftY = 11'sd185;
    frames(1);
    press_shoot();
    expect_ev(1'b1, 294, 169);
    frames(1);
    check("launch_pos_y", int'(missileTopLeftY), 169);
    frames(1);
    check("frame1_y", int'(missileTopLeftY), 165);
    press_shoot();
    frames(40);
    check("frame41_y", int'(missileTopLeftY), 5);
    check("frame41_active", int'(missileActive), 1);
    expect_ev(1'b0, 294, 1);
    frames(1);
    check("frame42_active", int'(missileActive), 0);

    // Cooldown: 8 ticks after retirement, launch only on the 9th.
    frames(7);
    press_shoot();
    frames(1);
    check("cool8_active", int'(missileActive), 0);
    shipTopLeftX = 11'sd100;
    shipTopLeftY = 11'sd300;
    press_shoot();
    pulse_collision();
    expect_ev(1'b1, 114, 284);
    frames(1);
    shipTopLeftX = 11'sd400;

    // Mid-flight collision at frame 3 retires on the next tick with Y held.
    frames(3);
    check("frame3_y", int'(missileTopLeftY), 272);
    check("no_track_x", int'(missileTopLeftX), 114);
    pulse_collision();
    expect_ev(1'b0, 114, 272);
    frames(1);
    check("hit_y_held", int'(missileTopLeftY), 272);

    // Held shoot fires once; collision on the tick cycle itself retires.
    shipTopLeftX = 11'sd200;
    shipTopLeftY = 11'sd100;
    frames(8);
    @(negedge clk) shoot = 1'b1;
    expect_ev(1'b1, 214, 84);
    frames(1);
    expect_ev(1'b0, 214, 84);
    frame_with_collision();
    check("tick_hit_active", int'(missileActive), 0);
    frames(10);
    @(negedge clk) shoot = 1'b0;

    // Frame-enable freeze mid-flight.
    press_shoot();
    expect_ev(1'b1, 214, 84);
    frames(3);
    check("pre_freeze_y", int'(missileTopLeftY), 76);
    enable_sof = 1'b0;
    frames(5);
    check("freeze_y", int'(missileTopLeftY), 76);
    check("freeze_active", int'(missileActive), 1);
    enable_sof = 1'b1;
    frames(1);
    check("resume1_y", int'(missileTopLeftY), 72);
    frames(1);
    check("resume2_y", int'(missileTopLeftY), 68);

    // Reset mid-flight; first tick only arms, the next can launch.
    expect_ev(1'b0, 0, 0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check("mid_rst_active", int'(missileActive), 0);
    check("mid_rst_x", int'(missileTopLeftX), 0);
    check("mid_rst_y", int'(missileTopLeftY), 0);
    press_shoot();
    frames(1);
    check("post_rst_tick_active", int'(missileActive), 0);
    press_shoot();
    expect_ev(1'b1, 214, 84);
    frames(1);
    check("relaunch_x", int'(missileTopLeftX), 214);
    check("relaunch_y", int'(missileTopLeftY), 84);

    repeat (4) @(negedge clk);
    check("events_pending", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spaceship_missile_move.md
# spaceship_missile_move

Player-missile trajectory stage directly downstream of the spaceship mover. It consumes the ship's `topLeftX`/`topLeftY` and the `shoot` key, and launches a single missile from the ship's nose. The missile climbs at a fixed speed, is retired on collision or at the top edge, then waits out a cooldown. Its outputs feed the missile bitmap/draw logic and the collision matrix.

## Interface
Parameters:
- `MISSILE_SPEED_Y`, default 256: upward speed in 1/64 px per frame (256 = 4 px/frame).
- `MISSILE_WIDTH`, default 4: missile width in px.
- `MISSILE_HEIGHT`, default 16: missile height in px.
- `SHIP_WIDTH`, default 32: ship width in px, used for nose centring.
- `COOLDOWN_FRAMES`, default 8: frames after retirement before the next launch; 0 means no cooldown.

Ports:
- `clk`, in, 1: system clock. One clock domain.
- `reset`, in, 1: reset is synchronous and active-high.
- `startOfFrame`, in, 1: one-cycle pulse at the start of each frame (30 Hz).
- `enable_sof`, in, 1: when low, `startOfFrame` is ignored and the missile freezes.
- `shoot`, in, 1: fire key level.
- `collision`, in, 1: missile pixel overlaps an alien or shield. Level, sampled every cycle.
- `shipTopLeftX`, in, signed 11: ship top-left X in px.
- `shipTopLeftY`, in, signed 11: ship top-left Y in px.
- `missileTopLeftX`, out, signed 11: missile top-left X in px.
- `missileTopLeftY`, out, signed 11: missile top-left Y in px.
- `missileActive`, out, 1: missile is in flight and must be drawn.
- `firePulse`, out, 1: one-cycle pulse on launch, used for sound and score logic.

## Operation
- Positions are held internally as `int` in fixed point ×64. Outputs are `Xpos/64` and `Ypos/64`, truncated.
- "Frame tick" means `startOfFrame && enable_sof`.
- State machine:
  - `IDLE_ST`: all outputs inactive. Frame tick → `READY_ST`.
  - `READY_ST`: a rising edge of `shoot` sets `fire_req`.
    - On a frame tick with `fire_req`: `Xpos = (shipTopLeftX + SHIP_WIDTH/2 - MISSILE_WIDTH/2)*64`, `Ypos = (shipTopLeftY - MISSILE_HEIGHT)*64`.
    - Same tick: `missileActive` ← 1, `firePulse` ← 1, `fire_req` ← 0, → `FLIGHT_ST`.
  - `FLIGHT_ST`: `collision` sets `hit_flag`. Frame tick → `SOF_ST`.
  - `SOF_ST`: if `hit_flag`: clear it, `missileActive` ← 0, load cooldown, → `COOLDOWN_ST`. Otherwise → `POSITION_CHANGE_ST`.
  - `POSITION_CHANGE_ST`: `Ypos` ← `Ypos - MISSILE_SPEED_Y`, → `POSITION_LIMITS_ST`.
  - `POSITION_LIMITS_ST`: if `Ypos < y_FRAME_TOP` (2*64): `missileActive` ← 0, load cooldown, → `COOLDOWN_ST`. Otherwise → `FLIGHT_ST`.
  - `COOLDOWN_ST`: `cool_cnt` decrements on each frame tick. At 0 → `READY_ST`.
- Loading the cooldown when `COOLDOWN_FRAMES == 0` goes straight to `READY_ST`.
- `shoot` edges are ignored outside `READY_ST`, and `fire_req` is cleared there, so there is no queued shot.
- `collision` is ignored unless in `FLIGHT_ST`.
- X never changes in flight: the missile does not track the ship.
- While inactive, the position outputs hold their last value; draw logic gates on `missileActive`.

## Timing
- Reset values: `missileActive=0`, `firePulse=0`, `missileTopLeftX=0`, `missileTopLeftY=0`, state `IDLE_ST`, `fire_req=0`, `hit_flag=0`, `cool_cnt=0`, `shoot_D=0`.
- `shoot` edge detect uses a 1-cycle delayed copy; `fire_req` is set in the cycle after the edge.
- Launch is registered on the frame-tick cycle. `missileActive` and the position are visible 1 cycle after the tick. `firePulse` is high for exactly that 1 cycle.
- Motion update happens 3 cycles after the tick (`SOF_ST` → `POSITION_CHANGE_ST` → `POSITION_LIMITS_ST`), well before the first active pixel.
- A collision in the same cycle as the frame tick is latched and acted on at that tick's `SOF_ST`.
- Collisions during the 3 update cycles are dropped.
- `reset` mid-flight: next cycle `missileActive=0` and state `IDLE_ST`. The first frame tick after reset only reaches `READY_ST`; no launch happens on it.
- `enable_sof` low freezes all frame-driven progress. `fire_req` and `hit_flag` are retained.

## Structure
- Shared package `space_invaders_pkg` holds:
  - `FIXED_POINT_MULTIPLIER` = 64.
  - Screen limits `SCREEN_W` = 640, `SCREEN_H` = 480, `SafetyMargin` = 2.
  - `y_FRAME_TOP`.
  - Missile state enum `missile_state_t` (3 bits).
- Sub-module `rise_edge_detect` (`clk`, `reset`, `in`, `pulse`) for `shoot`. It is reusable for the other key inputs.

## Test plan
- Ship at (280,185), `shoot` pulse, then frame tick → `firePulse` for 1 cycle; `missileActive=1`; missile at (294,169).
- Launch at (294,169), no collision → Y = 165 after frame 1; still active after frame 41 (Y=5); inactive at frame 42. `COOLDOWN_FRAMES=8` → next launch possible on the 9th tick after retirement.
- `collision` asserted 1 cycle mid-frame 3 of flight → `missileActive=0` right after the next tick's `SOF_ST`; Y unchanged from frame 3.
- `shoot` pressed during flight and during cooldown, released before `READY_ST` → no launch. `shoot` held continuously → exactly one launch, no auto-fire.
- `enable_sof=0` for 5 ticks mid-flight → Y constant; resuming continues at 4 px/frame.
- `reset` asserted 1 cycle mid-flight → `missileActive=0` and outputs (0,0) next cycle; one tick → `READY_ST`; a new shot launches on the following tick.
